sp_ram_rd_checker: RTL and testbench

- Read-back verification engine for a single-port RAM instance with registered read data.
- On a start pulse it sweeps every address in read mode and compares q against an address-derived expected pattern.
- Reports pass/fail, error count and first failing address.
- Sits beside the RAM as the reader/checker counterpart to the pattern writer that fills the RAM with data = address.

---
 rtl/sp_ram_rd_checker.sv | 143 ++++++++++++++
 tb/tb_sp_ram_rd_checker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_rd_checker.sv
// Read-back checker for a single-port RAM: sweeps all addresses, compares q to addr^seed.
// Optional SP_RAM_CHK_STOP_ON_ERR_EN: stop issuing reads after the first mismatch.
module sp_ram_rd_checker #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  ram_en,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  first_err_vld
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   seed_q;
  logic                    ram_en_q;
  logic [ADDR_WIDTH-1:0]   ram_addr_q;
  logic                    busy_q, done_q, pass_q;
  logic [ADDR_WIDTH:0]     err_cnt_q;
  logic [ADDR_WIDTH-1:0]   first_err_addr_q;
  logic                    first_err_vld_q;

  // Valid/address travel alongside each read so the compare lines up with ram_q.
  logic                    pipe_vld_q  [RD_LAT];
  logic [ADDR_WIDTH-1:0]   pipe_addr_q [RD_LAT];

  logic [ADDR_WIDTH-1:0]            cmp_addr;
  logic [DATA_WIDTH+ADDR_WIDTH-1:0] addr_wide;
  logic [DATA_WIDTH-1:0]            exp_data;
  logic                             mismatch;
  logic                             pipe_busy;
  logic                             stop_req;

  assign cmp_addr  = pipe_addr_q[RD_LAT-1];
  assign addr_wide = {{DATA_WIDTH{1'b0}}, cmp_addr};
  assign exp_data  = addr_wide[DATA_WIDTH-1:0] ^ seed_q;
  assign mismatch  = pipe_vld_q[RD_LAT-1] && (ram_q != exp_data);

  always_comb begin
    pipe_busy = 1'b0;
    for (int unsigned i = 0; i < RD_LAT; i++) pipe_busy = pipe_busy | pipe_vld_q[i];
  end

`ifdef SP_RAM_CHK_STOP_ON_ERR_EN
  assign stop_req = mismatch;
`else
  assign stop_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      seed_q           <= '0;
      ram_en_q         <= 1'b0;
      ram_addr_q       <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_cnt_q        <= '0;
      first_err_addr_q <= '0;
      first_err_vld_q  <= 1'b0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_vld_q[i]  <= 1'b0;
        pipe_addr_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0]  <= ram_en_q;
      pipe_addr_q[0] <= ram_addr_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_addr_q[i] <= pipe_addr_q[i-1];
      end

      if (mismatch) begin
        err_cnt_q <= err_cnt_q + 1'b1;
        if (!first_err_vld_q) begin
          first_err_addr_q <= cmp_addr;
          first_err_vld_q  <= 1'b1;
        end
      end

      done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q          <= READ;
            seed_q           <= seed;
            err_cnt_q        <= '0;
            pass_q           <= 1'b0;
            first_err_addr_q <= '0;
            first_err_vld_q  <= 1'b0;
            ram_addr_q       <= '0;
            ram_en_q         <= 1'b1;
            busy_q           <= 1'b1;
          end
        end
        READ: begin
          ram_addr_q <= ram_addr_q + 1'b1;
          if ((ram_addr_q == '1) || stop_req) begin
            ram_en_q <= 1'b0;
            state_q  <= DRAIN;
          end
        end
        DRAIN: begin
          if (!pipe_busy) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= (err_cnt_q == '0);
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_en         = ram_en_q;
  assign ram_wen        = 1'b0;
  assign ram_addr       = ram_addr_q;
  assign ram_din        = '0;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_addr_q;
  assign first_err_vld  = first_err_vld_q;

endmodule

// File: tb/tb_sp_ram_rd_checker.sv
// Directed bench for sp_ram_rd_checker with a behavioural registered-read RAM model.
`timescale 1ns/1ps
module tb_sp_ram_rd_checker;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 5;
  localparam int unsigned RL = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] seed = '0;
  logic          ram_en, ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_q;
  logic          busy, done, pass;
  logic [AW:0]   err_cnt;
  logic [AW-1:0] first_err_addr;
  logic          first_err_vld;

  int n_chk = 0;
  int n_err = 0;

  sp_ram_rd_checker #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_q(ram_q), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .first_err_vld(first_err_vld)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_pipe [RL];
  always @(posedge clk) begin
    if (ram_en) rd_pipe[0] <= mem[ram_addr];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_q = rd_pipe[RL-1];

  int wen_bad = 0;
  int max_addr = -1;
  always @(negedge clk) begin
    if (ram_wen !== 1'b0 || ram_din !== '0) wen_bad++;
    if (ram_en === 1'b1 && int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic fill(input logic [DW-1:0] x);
    for (int a = 0; a < 2**AW; a++) mem[a] = DW'(a) ^ x;
  endtask

  // Results of the latest sweep, captured in the done cycle.
  int            done_cyc, npulse;
  logic          r_pass, r_vld, r_busy, r_en, busy_mid, post_busy;
  logic [AW:0]   r_err;
  logic [AW-1:0] r_faddr;

  task automatic sweep(input logic [DW-1:0] sd, input bit mid, input bit at_done);
    done_cyc = -1; npulse = 0; post_busy = 1'b0; busy_mid = 1'b0;
    @(negedge clk); seed = sd; start = 1'b1; max_addr = -1;
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      if (k == 10) begin
        busy_mid = busy;
        if (mid) begin start = 1'b1; seed = 8'h33; end
      end
      if (done_cyc >= 0 && (busy || ram_en)) post_busy = 1'b1;
      if (done) begin
        npulse++;
        if (done_cyc < 0) begin
          done_cyc = k; r_pass = pass; r_err = err_cnt; r_vld = first_err_vld;
          r_faddr = first_err_addr; r_busy = busy; r_en = ram_en;
          if (at_done) start = 1'b1;
        end
      end
    end
  endtask

  initial begin
    fill(8'h00);
    for (int i = 0; i < RL; i++) rd_pipe[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {busy, done, pass, first_err_vld, ram_en, ram_wen}, 32'h0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_addr", ram_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean sweep
    sweep(8'h00, 1'b0, 1'b0);
    chk("clean_done_cyc", done_cyc, 34);
    chk("clean_pass", r_pass, 1);
    chk("clean_err", r_err, 0);
    chk("clean_vld", r_vld, 0);
    chk("clean_busy_mid", busy_mid, 1);
    chk("clean_busy_at_done", r_busy, 0);
    chk("clean_en_at_done", r_en, 0);
    chk("clean_pulses", npulse, 1);
    chk("clean_max_addr", max_addr, 31);
    chk("clean_pass_held", pass, 1);

    // Single fault
    fill(8'h00); mem[5] = 8'hFF;
    sweep(8'h00, 1'b0, 1'b0);
    chk("single_err", r_err, 1);
    chk("single_faddr", r_faddr, 5);
    chk("single_vld", r_vld, 1);
    chk("single_pass", r_pass, 0);

    // Multiple faults, last one retires during DRAIN
    fill(8'h00); mem[3] = 8'h00; mem[7] = 8'h55; mem[31] = 8'h00;
    sweep(8'h00, 1'b0, 1'b0);
    chk("multi_err", r_err, 3);
    chk("multi_faddr", r_faddr, 3);
    chk("multi_pass", r_pass, 0);

    // Seed pattern
    fill(8'hA5);
    sweep(8'hA5, 1'b0, 1'b0);
    chk("seed_pass", r_pass, 1);
    chk("seed_err", r_err, 0);
    sweep(8'h00, 1'b0, 1'b0);
    chk("seed0_err", r_err, 32);
    chk("seed0_faddr", r_faddr, 0);
    chk("seed0_pass", r_pass, 0);

    // start mid-sweep and during DONE must be ignored
    fill(8'h00);
    sweep(8'h00, 1'b1, 1'b1);
    chk("ign_done_cyc", done_cyc, 34);
    chk("ign_pass", r_pass, 1);
    chk("ign_pulses", npulse, 1);
    chk("ign_no_restart", post_busy, 0);

    // Reset mid-sweep
    fill(8'h00); mem[2] = 8'hFF;
    @(negedge clk); seed = 8'h00; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_err", err_cnt, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_async", {busy, done, pass, first_err_vld, ram_en}, 32'h0);
    @(negedge clk);
    chk("midrst_err", err_cnt, 0);
    chk("midrst_addr", {first_err_addr, ram_addr}, 0);
    rst_n = 1'b1;
    mem[2] = 8'h02;
    repeat (2) @(negedge clk);
    sweep(8'h00, 1'b0, 1'b0);
    chk("postrst_done_cyc", done_cyc, 34);
    chk("postrst_pass", r_pass, 1);

    // Fault at address 4
    fill(8'h00); mem[4] = 8'h44;
    sweep(8'h00, 1'b0, 1'b0);
    chk("a4_faddr", r_faddr, 4);
    chk("a4_err", r_err, 1);
    chk("a4_pass", r_pass, 0);
    chk("a4_pulses", npulse, 1);
`ifdef SP_RAM_CHK_STOP_ON_ERR_EN
    chk("a4_max_addr", max_addr, 5);
    chk("a4_done_cyc", done_cyc, 8);
`else
    chk("a4_max_addr", max_addr, 31);
    chk("a4_done_cyc", done_cyc, 34);
`endif

    chk("wen_din_zero", wen_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
